ram2e_rw_cmd: RTL and testbench
===============================

Name: ram2e_rw_cmd

Overview:
- Bank-register and command-sequence front end for the RAM2E card.
- Sits between the Apple IIe bus qualification (bank-register write strobe, data bus) and the SDRAM/UFM controllers.
- Holds the RAMWorks bank and capacity-mask registers and decodes the unlock sequence FF 00 55 AA C1 AD <cmd> <arg>.
- Issues sticky UFM program/erase requests and UFM data-register bitbang controls.

Parameters:
TOUT_BITS, 3, width of the idle-cycle timeout counter; sequence aborts after 2^TOUT_BITS consecutive non-select Apple cycles.
MASK_RST, 8'h7F, capacity AND-mask value after reset.

Ports:
C14M  in  1  14.318 MHz clock, all state on rising edge.
nRST  in  1  asynchronous active-low reset.
CycEnd  in  1  one-C14M pulse per Apple cycle, at the data-valid point (state C).
RWSel  in  1  level; bank-register write qualifier, sampled only when CycEnd=1.
Din  in  8  6502 data bus, sampled only when CycEnd=1.
MaskLoad  in  1  one-cycle pulse from UFM init; loads MaskIn.
MaskIn  in  8  capacity AND-mask restored from UFM.
ReqAck  in  1  one-cycle pulse from UFM controller; clears PrgmReq and EraseReq.
RWBank  out  8  current RAMWorks bank.
RWMask  out  8  current capacity AND-mask.
PrgmReq  out  1  sticky UFM program request.
EraseReq  out  1  sticky UFM erase request.
DRDIn  out  1  UFM data-register serial input.
DRCLK  out  1  UFM data-register clock pulse.
Seq  out  3  sequence state, debug.

Behaviour:
- Reset values: RWBank=00, RWMask=MASK_RST, Seq=0, PrgmReq=0, EraseReq=0, DRDIn=0, DRCLK=0, timeout=0, all arm flags=0.
- BankWr = CycEnd & RWSel. All sequence activity happens only on BankWr. Cycles with CycEnd=0 change nothing except DRCLK and the MaskLoad/ReqAck paths.
- Bank on every BankWr:
  - If FFArm=1: RWBank<=FF.
  - Otherwise: RWBank<=Din & RWMask, using the pre-update mask.
- Sequence advance, state s expects byte:
  - s0 FF, s1 00, s2 55, s3 AA, s4 C1, s5 AD.
  - Match: s<=s+1. Mismatch: s<=0. A mismatching FF in s1..s5 goes to 0, not 1.
  - s6 (command) and s7 (argument) always advance; s7 wraps to 0.
- Command in s6:
  - FFArm<=(Din==FF); BBArm<=(Din==EA); MaskArm<=(Din==E0).
  - EF sets PrgmReq; EE sets EraseReq. Any other byte arms nothing.
- Argument in s7:
  - If BBArm: DRDIn<=Din[6]; DRCLK asserts for exactly one C14M on the next cycle if Din[7]=1.
  - If MaskArm: RWMask<=Din.
- Arm clearing: every BankWr not in s6 clears FFArm, BBArm and MaskArm after using them.
- Timeout:
  - Counter increments on CycEnd & ~RWSel; BankWr clears it.
  - When it is at all-ones and another CycEnd & ~RWSel occurs: Seq<=0, counter wraps to 0.
  - Arm flags survive a timeout.
- PrgmReq/EraseReq: set only by s6 commands; cleared by ReqAck. If set and ReqAck occur in the same cycle, set wins.
- MaskLoad: RWMask<=MaskIn. If it coincides with an s7 MaskArm write, the Din write wins.
- DRCLK is never high for two consecutive cycles. DRCLK is 0 while nRST=0.
- Reset mid-sequence returns to s0 immediately, asynchronously, and drops any pending DRCLK pulse.

Test Plan:
- Reset, then BankWr Din=05 -> RWBank=05, Seq=0, all requests 0.
- BankWr FF,00,55,AA,C1,AD,EF,00 -> PrgmReq=1 after 7th write, Seq=0 after 8th. ReqAck -> PrgmReq=0. ReqAck coincident with a second EF command -> PrgmReq stays 1.
- FF,00,55,12 -> Seq=0 after the 4th write. Then FF,00,55,AA,C1,AD,E0,1F -> RWMask=1F. Next BankWr Din=FF -> RWBank=1F.
- FF,00,55 then 8 CycEnd with RWSel=0 -> Seq=0 on the 8th. Repeat with 7 idle cycles -> Seq stays 3, and AA continues to s4.
- Unlock + FF cmd + arg 00 -> RWBank=FF on the arg write. Next write Din=03 -> RWBank=03.
- Unlock + EA + arg C0 -> DRDIn=1 and DRCLK one-cycle pulse. Repeat with arg 40 -> DRDIn=1, no pulse. Assert nRST low during a pending pulse -> DRCLK stays 0.

Source files
------------

// File: rtl/ram2e_rw_cmd.sv
// ---------------------------------------------------------------------------
// ram2e_rw_cmd
//
// Bank-register and command-sequence front end for the RAM2E card.
//
// Every qualified bank-register write from the Apple IIe (CycEnd & RWSel)
// updates the RAMWorks bank register. The same writes feed a byte-sequence
// decoder that recognises the unlock sequence
//     FF 00 55 AA C1 AD <cmd> <arg>
// and acts on the command/argument pair:
//     cmd FF : next bank write forces RWBank to FF
//     cmd E0 : argument byte becomes the new capacity AND-mask
//     cmd EA : argument byte bit-bangs the UFM data register
//              (bit 6 -> DRDIn, bit 7 -> one DRCLK pulse)
//     cmd EF : sticky UFM program request
//     cmd EE : sticky UFM erase request
// A run of non-select Apple cycles longer than the timeout window abandons a
// partially entered sequence.
//
// Ports:
//   C14M      in   14.318 MHz clock; all state changes on its rising edge
//   nRST      in   asynchronous active-low reset
//   CycEnd    in   one-C14M pulse per Apple cycle at the data-valid point
//   RWSel     in   bank-register write qualifier (valid with CycEnd)
//   Din[7:0]  in   6502 data bus (valid with CycEnd)
//   MaskLoad  in   one-cycle pulse: load MaskIn into RWMask
//   MaskIn    in   capacity AND-mask restored from UFM
//   ReqAck    in   one-cycle pulse: clears PrgmReq and EraseReq
//   RWBank    out  current RAMWorks bank
//   RWMask    out  current capacity AND-mask
//   PrgmReq   out  sticky UFM program request
//   EraseReq  out  sticky UFM erase request
//   DRDIn     out  UFM data-register serial input
//   DRCLK     out  UFM data-register clock pulse (never two cycles wide)
//   Seq[2:0]  out  sequence state, for debug
// ---------------------------------------------------------------------------
module ram2e_rw_cmd #(
    parameter int unsigned TOUT_BITS = 3,
    parameter logic [7:0]  MASK_RST  = 8'h7F
) (
    input  logic       C14M,
    input  logic       nRST,
    input  logic       CycEnd,
    input  logic       RWSel,
    input  logic [7:0] Din,
    input  logic       MaskLoad,
    input  logic [7:0] MaskIn,
    input  logic       ReqAck,
    output logic [7:0] RWBank,
    output logic [7:0] RWMask,
    output logic       PrgmReq,
    output logic       EraseReq,
    output logic       DRDIn,
    output logic       DRCLK,
    output logic [2:0] Seq
);

    // Sequence states are named after the byte each one waits for; the last
    // two accept any byte (command, then argument).
    typedef enum logic [2:0] {
        S_FF  = 3'd0,
        S_00  = 3'd1,
        S_55  = 3'd2,
        S_AA  = 3'd3,
        S_C1  = 3'd4,
        S_AD  = 3'd5,
        S_CMD = 3'd6,
        S_ARG = 3'd7
    } seq_t;

    localparam logic [7:0] CMD_FFBANK = 8'hFF;
    localparam logic [7:0] CMD_BITBNG = 8'hEA;
    localparam logic [7:0] CMD_MASK   = 8'hE0;
    localparam logic [7:0] CMD_PRGM   = 8'hEF;
    localparam logic [7:0] CMD_ERASE  = 8'hEE;

    seq_t state;
    seq_t state_nxt;

    logic                 bank_wr;     // qualified bank-register write
    logic                 idle_cyc;    // Apple cycle that is not a bank write
    logic                 tout_hit;    // idle cycle with the counter saturated
    logic [TOUT_BITS-1:0] tout_cnt;

    logic [7:0] key_byte;              // byte expected in the current state
    logic       key_match;
    logic       cmd_wr;                // bank write landing in S_CMD
    logic       arg_wr;                // bank write landing in S_ARG

    logic ff_arm;                      // force next bank write to FF
    logic bb_arm;                      // argument drives UFM data register
    logic mask_arm;                    // argument becomes the new mask
    logic drclk_pend;                  // DRCLK pulse due on the next cycle

    assign bank_wr  = CycEnd & RWSel;
    assign idle_cyc = CycEnd & ~RWSel;
    assign tout_hit = idle_cyc & (&tout_cnt);

    // -----------------------------------------------------------------------
    // Sequence FSM: state register
    // -----------------------------------------------------------------------
    // NOTE: clocked state uses non-blocking assignments so every register in
    // the design samples the pre-edge values of the others (the bank write
    // below relies on this to see the old mask and old arm flags).
    always_ff @(posedge C14M or negedge nRST) begin
        if (!nRST) begin
            state <= S_FF;
        end else begin
            state <= state_nxt;
        end
    end

    // -----------------------------------------------------------------------
    // Sequence FSM: next-state logic
    // -----------------------------------------------------------------------
    // A bank write always takes priority over the timeout, which can only
    // fire on a non-select cycle anyway.
    // NOTE: state_nxt gets a default before any branch so no path through
    // the block leaves it unassigned (which would infer a latch).
    always_comb begin
        state_nxt = state;
        if (bank_wr) begin
            case (state)
                S_CMD:   state_nxt = S_ARG;
                S_ARG:   state_nxt = S_FF;
                // A wrong byte always restarts from S_FF, even if that byte
                // happens to be FF; it does not re-enter S_00.
                default: state_nxt = key_match ? seq_t'(state + 3'd1) : S_FF;
            endcase
        end else if (tout_hit) begin
            state_nxt = S_FF;
        end
    end

    // -----------------------------------------------------------------------
    // Sequence FSM: output / decode logic
    // -----------------------------------------------------------------------
    always_comb begin
        key_byte = 8'h00;
        case (state)
            S_FF:    key_byte = 8'hFF;
            S_00:    key_byte = 8'h00;
            S_55:    key_byte = 8'h55;
            S_AA:    key_byte = 8'hAA;
            S_C1:    key_byte = 8'hC1;
            S_AD:    key_byte = 8'hAD;
            default: key_byte = 8'h00;
        endcase
        key_match = (Din == key_byte);
        cmd_wr    = bank_wr && (state == S_CMD);
        arg_wr    = bank_wr && (state == S_ARG);
        Seq       = state;
    end

    // -----------------------------------------------------------------------
    // Idle-cycle timeout counter
    // -----------------------------------------------------------------------
    // Counts consecutive non-select Apple cycles; the increment past
    // all-ones wraps to zero in the same cycle the FSM is sent to S_FF.
    always_ff @(posedge C14M or negedge nRST) begin
        if (!nRST) begin
            tout_cnt <= '0;
        end else if (bank_wr) begin
            tout_cnt <= '0;
        end else if (idle_cyc) begin
            tout_cnt <= tout_cnt + TOUT_BITS'(1);
        end
    end

    // -----------------------------------------------------------------------
    // Arm flags
    // -----------------------------------------------------------------------
    // Set by the command byte, consumed and cleared by the very next bank
    // write wherever it lands. A timeout does not touch them, so an armed
    // FF still forces the next bank write after an abandoned sequence.
    always_ff @(posedge C14M or negedge nRST) begin
        if (!nRST) begin
            ff_arm   <= 1'b0;
            bb_arm   <= 1'b0;
            mask_arm <= 1'b0;
        end else if (cmd_wr) begin
            ff_arm   <= (Din == CMD_FFBANK);
            bb_arm   <= (Din == CMD_BITBNG);
            mask_arm <= (Din == CMD_MASK);
        end else if (bank_wr) begin
            ff_arm   <= 1'b0;
            bb_arm   <= 1'b0;
            mask_arm <= 1'b0;
        end
    end

    // -----------------------------------------------------------------------
    // Bank and mask registers
    // -----------------------------------------------------------------------
    // The bank is masked with the mask as it stood before this edge, so an
    // E0 argument write is itself masked by the outgoing mask.
    always_ff @(posedge C14M or negedge nRST) begin
        if (!nRST) begin
            RWBank <= 8'h00;
        end else if (bank_wr) begin
            RWBank <= ff_arm ? 8'hFF : (Din & RWMask);
        end
    end

    // A mask argument on the bus wins over a coincident UFM restore.
    always_ff @(posedge C14M or negedge nRST) begin
        if (!nRST) begin
            RWMask <= MASK_RST;
        end else if (arg_wr && mask_arm) begin
            RWMask <= Din;
        end else if (MaskLoad) begin
            RWMask <= MaskIn;
        end
    end

    // -----------------------------------------------------------------------
    // UFM program / erase requests
    // -----------------------------------------------------------------------
    // Sticky until acknowledged; a new command in the acknowledge cycle
    // keeps the request asserted.
    always_ff @(posedge C14M or negedge nRST) begin
        if (!nRST) begin
            PrgmReq  <= 1'b0;
            EraseReq <= 1'b0;
        end else begin
            PrgmReq  <= (cmd_wr && (Din == CMD_PRGM))  || (PrgmReq  && !ReqAck);
            EraseReq <= (cmd_wr && (Din == CMD_ERASE)) || (EraseReq && !ReqAck);
        end
    end

    // -----------------------------------------------------------------------
    // UFM data-register bit-bang
    // -----------------------------------------------------------------------
    // DRDIn changes on the argument write; the clock pulse follows one cycle
    // later so the data bit is already stable when DRCLK rises. Gating with
    // ~DRCLK guarantees the pulse is never two cycles wide.
    always_ff @(posedge C14M or negedge nRST) begin
        if (!nRST) begin
            DRDIn      <= 1'b0;
            drclk_pend <= 1'b0;
            DRCLK      <= 1'b0;
        end else begin
            if (arg_wr && bb_arm) begin
                DRDIn <= Din[6];
            end
            drclk_pend <= arg_wr && bb_arm && Din[7];
            DRCLK      <= drclk_pend && !DRCLK;
        end
    end

endmodule

// File: tb/tb_ram2e_rw_cmd.sv
// ---------------------------------------------------------------------------
// tb_ram2e_rw_cmd
//
// Directed stimulus for ram2e_rw_cmd. The driver pushes each expected
// output value into a scoreboard queue, tagged with the clock cycle after
// which it must hold; a separate monitor pops and compares on the falling
// edge of C14M, away from the active edge.
// ---------------------------------------------------------------------------
module tb_ram2e_rw_cmd;

    typedef enum {F_BANK, F_MASK, F_SEQ, F_PRGM, F_ERASE, F_DRDIN, F_DRCLK} field_t;

    typedef struct {
        string      name;
        field_t     f;
        logic [7:0] val;
        int         cyc;
    } exp_t;

    logic       C14M     = 1'b0;
    logic       nRST     = 1'b0;
    logic       CycEnd   = 1'b0;
    logic       RWSel    = 1'b0;
    logic [7:0] Din      = 8'h00;
    logic       MaskLoad = 1'b0;
    logic [7:0] MaskIn   = 8'h00;
    logic       ReqAck   = 1'b0;
    logic [7:0] RWBank;
    logic [7:0] RWMask;
    logic       PrgmReq;
    logic       EraseReq;
    logic       DRDIn;
    logic       DRCLK;
    logic [2:0] Seq;

    exp_t sb[$];
    int   cyc_cnt = 0;
    int   errors  = 0;
    int   checks  = 0;

    ram2e_rw_cmd #(
        .TOUT_BITS(3),
        .MASK_RST (8'h7F)
    ) dut (
        .C14M    (C14M),
        .nRST    (nRST),
        .CycEnd  (CycEnd),
        .RWSel   (RWSel),
        .Din     (Din),
        .MaskLoad(MaskLoad),
        .MaskIn  (MaskIn),
        .ReqAck  (ReqAck),
        .RWBank  (RWBank),
        .RWMask  (RWMask),
        .PrgmReq (PrgmReq),
        .EraseReq(EraseReq),
        .DRDIn   (DRDIn),
        .DRCLK   (DRCLK),
        .Seq     (Seq)
    );

    always #5 C14M = ~C14M;

    always @(posedge C14M) cyc_cnt <= cyc_cnt + 1;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %02h expected %02h (cycle %0d)", name, act, expv, cyc_cnt);
        end
    endtask

    // Monitor: compares every expectation due in the cycle just completed.
    always @(negedge C14M) begin : monitor
        exp_t       e;
        logic [7:0] act;
        while (sb.size() > 0 && sb[0].cyc <= cyc_cnt) begin
            e = sb.pop_front();
            case (e.f)
                F_BANK:  act = RWBank;
                F_MASK:  act = RWMask;
                F_SEQ:   act = {5'd0, Seq};
                F_PRGM:  act = {7'd0, PrgmReq};
                F_ERASE: act = {7'd0, EraseReq};
                F_DRDIN: act = {7'd0, DRDIn};
                default: act = {7'd0, DRCLK};
            endcase
            if (e.cyc != cyc_cnt) begin
                errors++;
                checks++;
                $display("FAIL %s: sample missed, due cycle %0d seen at %0d", e.name, e.cyc, cyc_cnt);
            end else begin
                check(e.name, act, e.val);
            end
        end
    end

    // Queue an expectation for the state after the next rising edge.
    task automatic ex(input string n, input field_t f, input logic [7:0] v);
        exp_t e;
        e.name = n;
        e.f    = f;
        e.val  = v;
        e.cyc  = cyc_cnt + 1;
        sb.push_back(e);
    endtask

    // Advance to the next falling edge and return strobes to idle.
    task automatic step();
        @(negedge C14M);
        CycEnd   = 1'b0;
        RWSel    = 1'b0;
        MaskLoad = 1'b0;
        ReqAck   = 1'b0;
    endtask

    task automatic bus(input logic sel, input logic [7:0] d);
        CycEnd = 1'b1;
        RWSel  = sel;
        Din    = d;
    endtask

    // Finish an Apple cycle: the strobe cycle plus one quiet cycle.
    task automatic fin();
        step();
        step();
    endtask

    task automatic wr_seq(input logic [7:0] d, input logic [7:0] s);
        bus(1'b1, d);
        ex("seq", F_SEQ, s);
        fin();
    endtask

    task automatic unlock();
        logic [7:0] keys [6];
        keys = '{8'hFF, 8'h00, 8'h55, 8'hAA, 8'hC1, 8'hAD};
        for (int i = 0; i < 6; i++) begin
            wr_seq(keys[i], 8'(i + 1));
        end
    endtask

    task automatic idles(input int n);
        for (int i = 0; i < n; i++) begin
            bus(1'b0, 8'h00);
            fin();
        end
    endtask

    task automatic bitbang(input logic [7:0] arg, input logic dr, input logic pulse);
        unlock();
        wr_seq(8'hEA, 8'd7);
        bus(1'b1, arg);
        ex("bb drdin", F_DRDIN, {7'd0, dr});
        ex("bb drclk early", F_DRCLK, 8'h00);
        step();
        ex("bb drclk pulse", F_DRCLK, {7'd0, pulse});
        step();
        ex("bb drclk end", F_DRCLK, 8'h00);
        step();
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : driver
        // Reset state, sampled while nRST is still low.
        step();
        ex("rst bank",  F_BANK,  8'h00);
        ex("rst mask",  F_MASK,  8'h7F);
        ex("rst seq",   F_SEQ,   8'h00);
        ex("rst prgm",  F_PRGM,  8'h00);
        ex("rst erase", F_ERASE, 8'h00);
        ex("rst drdin", F_DRDIN, 8'h00);
        ex("rst drclk", F_DRCLK, 8'h00);
        step();
        #1 nRST = 1'b1;
        step();

        // Plain bank write.
        bus(1'b1, 8'h05);
        ex("bank 05", F_BANK, 8'h05);
        ex("seq after 05", F_SEQ, 8'h00);
        ex("prgm idle", F_PRGM, 8'h00);
        ex("erase idle", F_ERASE, 8'h00);
        fin();

        // Program request, acknowledge, and set-beats-ack.
        unlock();
        bus(1'b1, 8'hEF);
        ex("EF seq", F_SEQ, 8'h07);
        ex("EF prgm", F_PRGM, 8'h01);
        ex("EF erase", F_ERASE, 8'h00);
        fin();
        bus(1'b1, 8'h00);
        ex("arg seq wrap", F_SEQ, 8'h00);
        ex("prgm held", F_PRGM, 8'h01);
        ex("arg bank", F_BANK, 8'h00);
        fin();
        ReqAck = 1'b1;
        ex("prgm ack", F_PRGM, 8'h00);
        step();
        unlock();
        bus(1'b1, 8'hEF);
        ReqAck = 1'b1;
        ex("prgm set wins", F_PRGM, 8'h01);
        fin();
        wr_seq(8'h00, 8'h00);
        ReqAck = 1'b1;
        ex("prgm ack 2", F_PRGM, 8'h00);
        step();

        // Erase request.
        unlock();
        bus(1'b1, 8'hEE);
        ex("EE erase", F_ERASE, 8'h01);
        ex("EE prgm", F_PRGM, 8'h00);
        fin();
        wr_seq(8'h00, 8'h00);
        ReqAck = 1'b1;
        ex("erase ack", F_ERASE, 8'h00);
        step();

        // Mismatches, including FF while in s1.
        bus(1'b1, 8'hFF);
        ex("s0 FF", F_SEQ, 8'h01);
        ex("bank FF&7F", F_BANK, 8'h7F);
        fin();
        wr_seq(8'hFF, 8'h00);
        wr_seq(8'hFF, 8'h01);
        wr_seq(8'h00, 8'h02);
        wr_seq(8'h55, 8'h03);
        wr_seq(8'h12, 8'h00);

        // Mask command.
        unlock();
        bus(1'b1, 8'hE0);
        ex("E0 seq", F_SEQ, 8'h07);
        ex("E0 bank", F_BANK, 8'h60);
        fin();
        bus(1'b1, 8'h1F);
        ex("mask 1F", F_MASK, 8'h1F);
        ex("mask arg bank", F_BANK, 8'h1F);
        ex("mask arg seq", F_SEQ, 8'h00);
        fin();
        bus(1'b1, 8'hFF);
        ex("bank masked 1F", F_BANK, 8'h1F);
        fin();
        bus(1'b1, 8'h12);
        ex("bank 12", F_BANK, 8'h12);
        ex("seq clean", F_SEQ, 8'h00);
        fin();

        // Timeout: 8 idle cycles abort, 7 do not.
        wr_seq(8'hFF, 8'h01);
        wr_seq(8'h00, 8'h02);
        wr_seq(8'h55, 8'h03);
        idles(6);
        bus(1'b0, 8'h00);
        ex("seq after 7 idle", F_SEQ, 8'h03);
        fin();
        bus(1'b0, 8'h00);
        ex("seq timeout", F_SEQ, 8'h00);
        fin();
        wr_seq(8'hFF, 8'h01);
        wr_seq(8'h00, 8'h02);
        wr_seq(8'h55, 8'h03);
        idles(7);
        wr_seq(8'hAA, 8'h04);
        wr_seq(8'h12, 8'h00);

        // Mask argument beats a coincident MaskLoad; old mask applies to bank.
        unlock();
        wr_seq(8'hE0, 8'h07);
        bus(1'b1, 8'h3F);
        MaskLoad = 1'b1;
        MaskIn   = 8'hAA;
        ex("mask din wins", F_MASK, 8'h3F);
        ex("bank old mask", F_BANK, 8'h1F);
        fin();
        MaskLoad = 1'b1;
        MaskIn   = 8'hFF;
        ex("maskload", F_MASK, 8'hFF);
        step();

        // FF command forces the argument write to bank FF.
        unlock();
        wr_seq(8'hFF, 8'h07);
        bus(1'b1, 8'h00);
        ex("ffarm bank", F_BANK, 8'hFF);
        ex("ffarm seq", F_SEQ, 8'h00);
        fin();
        bus(1'b1, 8'h03);
        ex("ffarm cleared", F_BANK, 8'h03);
        fin();

        // UFM bit-bang.
        bitbang(8'hC0, 1'b1, 1'b1);
        bitbang(8'h00, 1'b0, 1'b0);
        bitbang(8'h40, 1'b1, 1'b0);

        // Reset while a DRCLK pulse is pending.
        unlock();
        wr_seq(8'hEA, 8'h07);
        bus(1'b1, 8'h80);
        ex("pend drdin", F_DRDIN, 8'h00);
        ex("pend drclk", F_DRCLK, 8'h00);
        step();
        #1 nRST = 1'b0;
        ex("rst drops pulse", F_DRCLK, 8'h00);
        ex("rst2 mask", F_MASK, 8'h7F);
        ex("rst2 bank", F_BANK, 8'h00);
        step();
        #1 nRST = 1'b1;
        ex("after rst drclk", F_DRCLK, 8'h00);
        step();

        // Reset mid-sequence.
        wr_seq(8'hFF, 8'h01);
        wr_seq(8'h00, 8'h02);
        #1 nRST = 1'b0;
        ex("rst mid seq", F_SEQ, 8'h00);
        step();
        #1 nRST = 1'b1;
        step();

        step();
        step();
        if (sb.size() != 0) begin
            errors++;
            checks++;
            $display("FAIL scoreboard drain: %0d expectations left, expected 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
